// File: rtl/or_sched_pkg.sv
// Shared types and helpers for the OR-unit round-robin scheduler.
package or_sched_pkg;

  // IDLE: result register empty. HOLD: result waiting for the consumer.
  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } or_sched_state_e;

  // Priority pointer advance with an explicit wrap.
  // Works even when nreq is not a power of two.
  function automatic int unsigned next_rr(input int unsigned g, input int unsigned nreq);
    return (g == nreq - 1) ? 0 : g + 1;
  endfunction

endpackage

// File: rtl/or_unit_arbiter_gate_or.sv
// Gate_or: the shared N-bit bitwise OR datapath (no carry, no extension).
module Gate_or #(
  parameter int N = 4
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic [N-1:0] f_o
);

  assign f_o = a_i | b_i;

endmodule

// File: rtl/or_unit_arbiter.sv
// Round-robin scheduler sharing one Gate_or among NREQ requesters.
// It registers one result per cycle, tagged with the requester ID.
module or_unit_arbiter
  import or_sched_pkg::*;
#(
  parameter  int N    = 4,
  parameter  int NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*N-1:0] req_a,
  input  logic [NREQ*N-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [N-1:0]      res_data,
  output logic [IDW-1:0]    res_id,
  output logic              busy
);

  or_sched_state_e state_q;
  logic [N-1:0]    res_data_q;
  logic [IDW-1:0]  res_id_q;
  logic [IDW-1:0]  rr_ptr_q;

  logic            grant_found;
  logic [IDW-1:0]  grant_idx;
  logic [IDW:0]    cand;
  logic            slot_free;
  logic            accept;
  logic [N-1:0]    a_g;
  logic [N-1:0]    b_g;
  logic [N-1:0]    f_g;

  // Search for the first valid requester, starting at rr_ptr and wrapping.
  always_comb begin
    // NOTE: every variable gets a default before the loop. A path that
    // leaves one unassigned would infer a latch.
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, rr_ptr_q} + (IDW+1)'(k);
      if (cand >= (IDW+1)'(NREQ)) begin
        cand = cand - (IDW+1)'(NREQ);
      end
      if (!grant_found && req_valid[cand[IDW-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[IDW-1:0];
      end
    end
  end

  // A held result consumed this cycle frees the slot, so throughput is one
  // result per cycle. Grants are suppressed while reset is asserted.
  assign slot_free = (state_q == IDLE) | res_ready;
  assign accept    = slot_free & grant_found & ~rst;
  assign req_ready = accept ? (NREQ'(1) << grant_idx) : '0;

  assign a_g = req_a[grant_idx*N +: N];
  assign b_g = req_b[grant_idx*N +: N];

  Gate_or #(.N(N)) u_gate_or (
    .a_i (a_g),
    .b_i (b_g),
    .f_o (f_g)
  );

  // Result register, FSM state and round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      res_data_q <= '0;
      res_id_q   <= '0;
      rr_ptr_q   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments. All registers
      // then update together from the values that were present before the edge.
      case (state_q)
        IDLE: begin
          if (accept) begin
            res_data_q <= f_g;
            res_id_q   <= grant_idx;
            rr_ptr_q   <= IDW'(next_rr(32'(grant_idx), NREQ));
            state_q    <= HOLD;
          end
        end
        HOLD: begin
          if (accept) begin
            res_data_q <= f_g;
            res_id_q   <= grant_idx;
            rr_ptr_q   <= IDW'(next_rr(32'(grant_idx), NREQ));
          end else if (res_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign res_valid = (state_q == HOLD);
  assign busy      = res_valid;
  assign res_data  = res_data_q;
  assign res_id    = res_id_q;

endmodule
